// File: rtl/osc_timer_pkg.sv
// Shared encodings and default sizing for the oscillator timer.
package osc_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        ONESHOT  = 1'b0,
        PERIODIC = 1'b1
    } mode_t;

    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_PRE_DIV   = 4;

endpackage

// File: rtl/osc_prescaler.sv
// Free-running prescaler: emits a one-cycle TICK every PRE_DIV enabled cycles.
module osc_prescaler
    import osc_timer_pkg::*;
#(
    parameter int PRE_DIV = DEF_PRE_DIV
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    // A ratio of 1 still needs a one-bit phase register; it simply never leaves 0.
    localparam int            PW   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRE_DIV - 1);

    logic [PW-1:0] phase;

    // Phase counter: clear wins over advance, wraps after the last phase.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            phase <= '0;
        end else if (CLR) begin
            phase <= '0;
        end else if (EN) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    assign TICK = EN && (phase == LAST);

endmodule

// File: rtl/osc_timer.sv
// Down-counting timer clocked from the on-chip oscillator, one-shot or periodic.
module osc_timer
    import osc_timer_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int PRE_DIV   = DEF_PRE_DIV
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 LOAD,
    input  logic [CNT_WIDTH-1:0] PERIOD,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 MODE,
    output logic [CNT_WIDTH-1:0] COUNT,
    output logic                 BUSY,
    output logic                 TICK,
    output logic                 TC
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t                 state, state_n;
    mode_t                  mode_q, mode_n;
    logic [CNT_WIDTH-1:0]   count_q, count_n;
    logic [CNT_WIDTH-1:0]   period_q, period_n;
    logic [CNT_WIDTH-1:0]   eff_period;
    logic                   tc_q, tc_n;
    logic                   presc_clr;
    logic                   tick;

    osc_prescaler #(
        .PRE_DIV (PRE_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (state == RUN),
        .CLR  (presc_clr),
        .TICK (tick)
    );

    // Next-state logic: STOP beats START, START beats the terminal tick.
    always_comb begin
        state_n    = state;
        mode_n     = mode_q;
        count_n    = count_q;
        period_n   = period_q;
        tc_n       = 1'b0;
        presc_clr  = 1'b0;
        eff_period = LOAD ? PERIOD : period_q;

        if (LOAD) begin
            period_n = PERIOD;
        end

        if (STOP) begin
            state_n   = IDLE;
            presc_clr = 1'b1;
        end else if (START && (eff_period != '0)) begin
            state_n   = RUN;
            count_n   = eff_period;
            mode_n    = mode_t'(MODE);
            presc_clr = 1'b1;
        end else if ((state == RUN) && tick) begin
            if (count_q > ONE) begin
                count_n = count_q - ONE;
            end else if (count_q == ONE) begin
                // Back-to-back terminal ticks (ratio 1, period 1) would hold TC
                // high; suppressing every second one keeps it a single pulse.
                tc_n = ~tc_q;
                if (mode_q == PERIODIC) begin
                    count_n = period_q;
                end else begin
                    count_n = '0;
                    state_n = IDLE;
                end
            end
        end
    end

    // State and datapath registers; reset clears everything including the period.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state    <= IDLE;
            mode_q   <= ONESHOT;
            count_q  <= '0;
            period_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            count_q  <= count_n;
            period_q <= period_n;
            tc_q     <= tc_n;
        end
    end

    assign COUNT = count_q;
    assign BUSY  = (state == RUN);
    assign TICK  = tick;
    assign TC    = tc_q;

endmodule

// File: tb/tb_osc_timer.sv
// Bench for osc_timer: behavioural model with per-cycle compare, directed literal checks,
// random traffic, and a second instance with a prescaler ratio of 1.
module tb_osc_timer;

    localparam int CW = 8;
    localparam int PD = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          load, start, stop, mode;
    logic [CW-1:0] period;
    logic [CW-1:0] count;
    logic          busy, tick, tc;

    logic          load2, start2, stop2, mode2;
    logic [CW-1:0] period2;
    logic [CW-1:0] count2;
    logic          busy2, tick2, tc2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    osc_timer #(.CNT_WIDTH(CW), .PRE_DIV(PD)) dut (
        .CLK(clk), .RSTN(rstn), .LOAD(load), .PERIOD(period), .START(start),
        .STOP(stop), .MODE(mode), .COUNT(count), .BUSY(busy), .TICK(tick), .TC(tc)
    );

    osc_timer #(.CNT_WIDTH(CW), .PRE_DIV(1)) dut1 (
        .CLK(clk), .RSTN(rstn), .LOAD(load2), .PERIOD(period2), .START(start2),
        .STOP(stop2), .MODE(mode2), .COUNT(count2), .BUSY(busy2), .TICK(tick2), .TC(tc2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: time in RUN is counted in cycles, ticks fall on every
    // PD-th cycle since the last start.
    bit m_run, m_mode, m_tc;
    int m_count, m_period, m_age;

    function automatic bit m_tick();
        return m_run && ((m_age % PD) == PD - 1);
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_run = 0; m_mode = 0; m_tc = 0;
            m_count = 0; m_period = 0; m_age = 0;
        end else begin
            bit tk, new_tc;
            int eff, old_period;
            tk         = m_tick();
            new_tc     = 0;
            old_period = m_period;
            eff        = load ? int'(period) : m_period;
            if (load) m_period = int'(period);
            if (stop) begin
                m_run = 0;
                m_age = 0;
            end else if (start && eff != 0) begin
                m_run = 1; m_count = eff; m_mode = mode; m_age = 0;
            end else if (m_run) begin
                if (tk) begin
                    if (m_count > 1) m_count = m_count - 1;
                    else if (m_count == 1) begin
                        new_tc = !m_tc;
                        if (m_mode) m_count = old_period;
                        else begin
                            m_count = 0;
                            m_run   = 0;
                        end
                    end
                end
                m_age++;
            end
            m_tc = new_tc;
        end
    end

    // Compare DUT against model every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_count", count, m_count);
            check("cyc_busy",  busy,  m_run);
            check("cyc_tick",  tick,  m_tick());
            check("cyc_tc",    tc,    m_tc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tc(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step(1);
            if (tc) begin
                n = i;
                return;
            end
        end
        n = -1;
    endtask

    initial begin
        int n;
        rstn = 0; load = 0; start = 0; stop = 0; mode = 0; period = '0;
        load2 = 0; start2 = 0; stop2 = 0; mode2 = 0; period2 = '0;
        step(2);
        check("rst_count", count, 0);
        check("rst_busy",  busy,  0);
        check("rst_tick",  tick,  0);
        check("rst_tc",    tc,    0);
        rstn = 1;
        chk_en = 1;

        // One-shot, period 3
        load = 1; period = 3; step(1); load = 0;
        start = 1; mode = 0; step(1); start = 0;
        check("os_e0_count", count, 3);
        check("os_e0_busy",  busy,  1);
        check("os_e0_tick",  tick,  0);
        step(3);
        check("os_e3_tick",  tick,  1);
        check("os_e3_count", count, 3);
        step(1);
        check("os_e4_count", count, 2);
        step(4);
        check("os_e8_count", count, 1);
        step(3);
        check("os_e11_tick", tick, 1);
        check("os_e11_tc",   tc,   0);
        step(1);
        check("os_e12_tc",    tc,    1);
        check("os_e12_count", count, 0);
        check("os_e12_busy",  busy,  0);
        step(1);
        check("os_e13_tc", tc, 0);

        // Periodic, period 2, then reload with 5
        load = 1; period = 2; start = 1; mode = 1; step(1);
        load = 0; start = 0;
        for (int k = 0; k < 5; k++) begin
            wait_tc(n);
            check("per_interval8", n, 8);
        end
        load = 1; period = 5; step(1); load = 0;
        wait_tc(n);
        check("per_before_reload", n, 7);
        wait_tc(n);
        check("per_interval20", n, 20);
        stop = 1; step(1); stop = 0;
        check("per_stop_busy", busy, 0);

        // STOP coincident with terminal tick
        load = 1; period = 1; start = 1; mode = 0; step(1);
        load = 0; start = 0;
        step(3);
        check("stop_pre_tick",  tick,  1);
        check("stop_pre_count", count, 1);
        stop = 1; step(1); stop = 0;
        check("stop_busy",  busy,  0);
        check("stop_count", count, 1);
        check("stop_tc",    tc,    0);
        step(1);
        check("stop_tc_late", tc, 0);

        // Zero period is ignored; LOAD with START uses the new period
        rstn = 0; step(1); rstn = 1;
        start = 1; step(1); start = 0;
        check("zero_busy", busy, 0);
        step(1);
        check("zero_tc", tc, 0);
        load = 1; period = 4; start = 1; mode = 0; step(1);
        load = 0; start = 0;
        step(15);
        check("ls_e15_tc", tc, 0);
        step(1);
        check("ls_e16_tc", tc, 1);

        // Reset mid-run
        load = 1; period = 6; start = 1; mode = 1; step(1);
        load = 0; start = 0;
        step(5);
        rstn = 0; step(1);
        check("rr_count", count, 0);
        check("rr_busy",  busy,  0);
        check("rr_tick",  tick,  0);
        check("rr_tc",    tc,    0);
        rstn = 1;
        start = 1; step(1); start = 0;
        check("rr_restart_busy", busy, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn   = ($urandom_range(0, 99) != 0);
            load   = ($urandom_range(0, 9) == 0);
            period = CW'($urandom_range(0, 7));
            start  = ($urandom_range(0, 19) == 0);
            stop   = ($urandom_range(0, 39) == 0);
            mode   = 1'($urandom_range(0, 1));
            step(1);
        end
        rstn = 1; load = 0; start = 0; stop = 0;
        step(2);

        // Ratio 1, period 1, periodic: TICK always high, TC alternates
        load2 = 1; period2 = 1; mode2 = 1; start2 = 1; step(1);
        load2 = 0; start2 = 0;
        for (int k = 1; k <= 8; k++) begin
            check("pd1_tick", tick2, 1);
            check("pd1_busy", busy2, 1);
            step(1);
            check("pd1_tc", tc2, k % 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_timer.md
OSC_TIMER -- requirements
Module: osc_timer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the period register and the down-counter; legal range 2..32.
REQ-002 Parameter PRE_DIV, default 4: prescaler ratio in CLK cycles per TICK; legal range 1..256.
REQ-003 CLK  input  1  free-running internal oscillator clock (CFGCLK of the on-chip oscillator); the only clock in the block.
REQ-004 RSTN  input  1  reset, synchronous, active-low.
REQ-005 LOAD  input  1  captures PERIOD into the period register.
REQ-006 PERIOD  input  CNT_WIDTH  timer period, in TICKs.
REQ-007 START  input  1  starts or restarts the timer.
REQ-008 STOP  input  1  aborts the timer.
REQ-009 MODE  input  1  0 = one-shot, 1 = periodic; sampled on START.
REQ-010 COUNT  output  CNT_WIDTH  current down-counter value.
REQ-011 BUSY  output  1  high while the timer is in RUN.
REQ-012 TICK  output  1  prescaler enable; combinational, high for one CLK cycle every PRE_DIV cycles while in RUN.
REQ-013 TC  output  1  registered one-cycle terminal-count pulse.

Function
REQ-014 The timer SHALL have two states: IDLE and RUN.
REQ-015 In IDLE, START with a nonzero effective period SHALL load COUNT with the period, clear the prescaler, latch MODE, and enter RUN at the same edge.
REQ-016 In IDLE, START with an effective period of 0 SHALL be ignored; the timer stays in IDLE and TC stays low.
REQ-017 The effective period SHALL be PERIOD when LOAD and START are high in the same cycle, and the period register otherwise.
REQ-018 In RUN, the prescaler SHALL count 0..PRE_DIV-1 and wrap to 0.
REQ-019 TICK SHALL be high when the state is RUN and the prescaler equals PRE_DIV-1 (with PRE_DIV=1, TICK is high on every RUN cycle).
REQ-020 On a TICK with COUNT > 1, COUNT SHALL decrement by 1.
REQ-021 On a TICK with COUNT == 1 in one-shot mode: COUNT <= 0, state <= IDLE, TC <= 1.
REQ-022 On a TICK with COUNT == 1 in periodic mode: COUNT <= the period register, state stays RUN, TC <= 1.
REQ-023 TC SHALL be low in every cycle except the one following a terminal TICK; TC is never held for two cycles.
REQ-024 The first TC SHALL appear on edge E0 + PERIOD*PRE_DIV, where E0 is the edge that sampled START.
REQ-025 LOAD while in RUN SHALL update only the period register; the new value takes effect at the next periodic reload or the next START.
REQ-026 START while in RUN SHALL restart the timer: COUNT reloads, the prescaler clears, and no TC is generated for the aborted period.
REQ-027 STOP SHALL return the timer to IDLE at the next edge and clear the prescaler; COUNT holds its value and no TC is generated.
REQ-028 STOP SHALL take priority over START and over a coincident terminal TICK.
REQ-029 BUSY SHALL equal (state == RUN), registered.

Reset
REQ-030 With RSTN low at an edge: state = IDLE, COUNT = 0, period register = 0, prescaler = 0, TC = 0, MODE latch = 0; BUSY and TICK therefore read 0.
REQ-031 Reset asserted mid-RUN SHALL abort without a TC pulse; it overrides all other inputs.

Structure
REQ-032 A shared package SHALL hold the state encoding constants (IDLE, RUN), the MODE encodings (ONESHOT, PERIODIC), and the default CNT_WIDTH and PRE_DIV values.
REQ-033 The prescaler SHALL be a sub-module named osc_prescaler (inputs CLK, RSTN, EN, CLR; output TICK).
REQ-034 There SHALL be no other clocks, no derived clocks, and no latches.

Verification (CNT_WIDTH=8, PRE_DIV=4 unless stated)
REQ-035 LOAD PERIOD=3, then START with MODE=0 at E0 -> TICK at E3, E7, E11; COUNT 3,2,1,0; TC high for exactly one cycle after E12; BUSY falls at E12.
REQ-036 PERIOD=2, MODE=1 -> TC every 8 cycles for 5 periods; LOAD 5 mid-run -> the interval after the next reload is 20 cycles.
REQ-037 RUN with COUNT=1 and the prescaler at 3, with STOP asserted in that cycle -> IDLE, no TC, COUNT holds 1.
REQ-038 START with the period register at 0 -> BUSY stays 0 and no TC; LOAD 4 with START in the same cycle -> TC at E0+16.
REQ-039 RSTN low for 1 cycle mid-RUN -> all outputs 0 at the next edge, no TC; a subsequent START requires a new LOAD.
REQ-040 PRE_DIV=1 with PERIOD=1 in periodic mode -> TICK constantly high and TC high every other cycle (alternating 0/1).
